// File: rtl/counter_control_unit_if.sv
// Command and status bundle between the button/RX front end and the counter control FSM.
// The master drives command pulses; the slave (control unit) drives the datapath levels.
interface counter_control_unit_if;
    logic       btn_run_stop;
    logic       btn_clear;
    logic       btn_mode;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       enable;
    logic       clear;
    logic       mode;
    logic [1:0] state;
    logic       cmd_drop;

    modport master (
        output btn_run_stop, btn_clear, btn_mode, rx_data, rx_valid,
        input  enable, clear, mode, state, cmd_drop
    );

    modport slave (
        input  btn_run_stop, btn_clear, btn_mode, rx_data, rx_valid,
        output enable, clear, mode, state, cmd_drop
    );
endinterface

// File: rtl/counter_control_unit.sv
// Control FSM (STOP/RUN/CLEAR) for the 10 Hz up/down counter datapath.
// Define COUNTER_CMD_RX_EN to compile in the serial RX command path and its arbitration.
module counter_control_unit #(
    parameter int unsigned CLEAR_CYCLES = 2,
    parameter logic [7:0]  CMD_RUN      = 8'h52,
    parameter logic [7:0]  CMD_CLEAR    = 8'h43,
    parameter logic [7:0]  CMD_MODE     = 8'h4D
) (
    input  logic                   clk,
    input  logic                   rst,
    counter_control_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_RS   = 2'd1,
        CMD_CLR  = 2'd2,
        CMD_MD   = 2'd3
    } cmd_e;

    localparam logic [3:0] CLR_LOAD = 4'(CLEAR_CYCLES - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       mode_q, mode_d;
    logic       drop_q, drop_d;
    cmd_e       btn_cmd;
    cmd_e       cmd;

    // Simultaneous buttons collapse to one command: clear, then run/stop, then mode.
    always_comb begin
        btn_cmd = CMD_NONE;
        if (bus.btn_clear)
            btn_cmd = CMD_CLR;
        else if (bus.btn_run_stop)
            btn_cmd = CMD_RS;
        else if (bus.btn_mode)
            btn_cmd = CMD_MD;
    end

`ifdef COUNTER_CMD_RX_EN
    cmd_e rx_cmd;

    always_comb begin
        rx_cmd = CMD_NONE;
        if (bus.rx_valid) begin
            if (bus.rx_data == CMD_RUN)
                rx_cmd = CMD_RS;
            else if (bus.rx_data == CMD_CLEAR)
                rx_cmd = CMD_CLR;
            else if (bus.rx_data == CMD_MODE)
                rx_cmd = CMD_MD;
        end
    end

    // Buttons win; a losing RX command is only reported when it could have acted.
    always_comb begin
        cmd    = (btn_cmd != CMD_NONE) ? btn_cmd : rx_cmd;
        drop_d = (rx_cmd != CMD_NONE) && (btn_cmd != CMD_NONE) && (state_q != ST_CLEAR);
    end
`else
    logic rx_unused;
    assign rx_unused = ^{bus.rx_data, bus.rx_valid};

    always_comb begin
        cmd    = btn_cmd;
        drop_d = 1'b0;
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            ST_STOP, ST_RUN: begin
                case (cmd)
                    CMD_RS:  state_d = (state_q == ST_STOP) ? ST_RUN : ST_STOP;
                    CMD_CLR: begin
                        state_d = ST_CLEAR;
                        cnt_d   = CLR_LOAD;
                    end
                    CMD_MD:  mode_d = ~mode_q;
                    default: ;
                endcase
            end
            ST_CLEAR: begin
                // All commands are ignored until the clear window has elapsed.
                if (cnt_q == 4'd0)
                    state_d = ST_STOP;
                else
                    cnt_d = cnt_q - 4'd1;
            end
            default: state_d = ST_STOP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_STOP;
            cnt_q   <= 4'd0;
            mode_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.enable   = (state_q == ST_RUN);
    assign bus.clear    = (state_q == ST_CLEAR);
    assign bus.mode     = mode_q;
    assign bus.state    = state_q;
    assign bus.cmd_drop = drop_q;

endmodule

// File: tb/tb_counter_control_unit.sv
// Self-checking bench for counter_control_unit: vector table plus hand-written reset/clear sequences.
// Expectations follow COUNTER_CMD_RX_EN the same way the design build does.
module tb_counter_control_unit;

`ifdef COUNTER_CMD_RX_EN
    localparam bit RX = 1'b1;
`else
    localparam bit RX = 1'b0;
`endif

    localparam logic [1:0] S_STOP = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_CLR  = 2'd2;

    typedef struct {
        logic       rs;
        logic       cl;
        logic       md;
        logic       rv;
        logic [7:0] rd;
        logic [1:0] st;
        logic       mode;
        logic       drop;
    } vec_t;

    typedef struct {
        logic [1:0] st;
        logic       mode;
        logic       drop;
        int         id;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb_q[$];
    vec_t vecs[$];

    counter_control_unit_if bus();

    counter_control_unit #(
        .CLEAR_CYCLES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rs, cl, md, rv, input logic [7:0] rd,
                                input logic [1:0] st, input logic mode, drop);
        vec_t v;
        v.rs = rs; v.cl = cl; v.md = md; v.rv = rv; v.rd = rd;
        v.st = st; v.mode = mode; v.drop = drop;
        return v;
    endfunction

    task automatic drive(input logic rs, cl, md, rv, input logic [7:0] rd);
        bus.btn_run_stop = rs;
        bus.btn_clear    = cl;
        bus.btn_mode     = md;
        bus.rx_valid     = rv;
        bus.rx_data      = rd;
    endtask

    task automatic push_exp(input logic [1:0] st, input logic mode, drop, input int id);
        exp_t e;
        e.st = st; e.mode = mode; e.drop = drop; e.id = id;
        sb_q.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        logic [5:0] act, req;
        e   = sb_q.pop_front();
        act = {bus.state, bus.enable, bus.clear, bus.mode, bus.cmd_drop};
        req = {e.st, e.st == S_RUN, e.st == S_CLR, e.mode, e.drop};
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL vec%0d {state,en,clr,mode,drop}: got %b required %b", e.id, act, req);
        end else begin
            $display("vec%0d ok {state,en,clr,mode,drop}=%b", e.id, act);
        end
    endtask

    // One clock of stimulus; the outcome is compared 1 time unit after the sampling edge.
    task automatic cycle(input logic rs, cl, md, rv, input logic [7:0] rd,
                         input logic [1:0] st, input logic mode, drop, input int id);
        @(negedge clk);
        drive(rs, cl, md, rv, rd);
        push_exp(st, mode, drop, id);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 8'h00);
        check_pop();
    endtask

    task automatic async_reset_check(input int id);
        #1 rst = 1'b1;
        #1;
        push_exp(S_STOP, 1'b0, 1'b0, id);
        check_pop();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic m;
        rst = 1'b1;
        drive(0, 0, 0, 0, 8'h00);
        #12;
        push_exp(S_STOP, 1'b0, 1'b0, 0);
        check_pop();
        @(negedge clk);
        rst = 1'b0;

        m = RX ? 1'b0 : 1'b1;
        vecs.push_back(mk(0,0,0,0,8'h00, S_STOP, 0, 0));
        vecs.push_back(mk(1,0,0,0,8'h00, S_RUN,  0, 0));
        vecs.push_back(mk(0,0,0,0,8'h00, S_RUN,  0, 0));
        vecs.push_back(mk(0,0,0,0,8'h00, S_RUN,  0, 0));
        vecs.push_back(mk(1,0,0,0,8'h00, S_STOP, 0, 0));
        vecs.push_back(mk(0,0,1,0,8'h00, S_STOP, 1, 0));
        vecs.push_back(mk(1,0,0,0,8'h00, S_RUN,  1, 0));
        vecs.push_back(mk(0,0,0,1,8'h4D, S_RUN,  m, 0));
        vecs.push_back(mk(0,0,0,1,8'h41, S_RUN,  m, 0));
        vecs.push_back(mk(1,0,0,0,8'h00, S_STOP, m, 0));
        vecs.push_back(mk(1,0,0,1,8'h43, S_RUN,  m, RX));
        vecs.push_back(mk(0,0,0,0,8'h00, S_RUN,  m, 0));
        vecs.push_back(mk(0,1,0,0,8'h00, S_CLR,  m, 0));
        vecs.push_back(mk(1,0,1,0,8'h00, S_CLR,  m, 0));
        vecs.push_back(mk(0,0,0,1,8'h52, S_STOP, m, 0));
        vecs.push_back(mk(0,0,0,0,8'h00, S_STOP, m, 0));
        vecs.push_back(mk(1,1,1,0,8'h00, S_CLR,  m, 0));
        vecs.push_back(mk(0,0,0,0,8'h00, S_CLR,  m, 0));
        vecs.push_back(mk(0,0,0,0,8'h00, S_STOP, m, 0));
        vecs.push_back(mk(0,0,0,1,8'h52, RX ? S_RUN : S_STOP, m, 0));
        vecs.push_back(mk(0,0,0,1,8'h43, RX ? S_CLR : S_STOP, m, 0));
        vecs.push_back(mk(0,0,0,0,8'h00, RX ? S_CLR : S_STOP, m, 0));
        vecs.push_back(mk(0,0,0,0,8'h00, S_STOP, m, 0));
        vecs.push_back(mk(0,0,1,1,8'h4D, S_STOP, ~m, RX));
        vecs.push_back(mk(1,0,1,0,8'h00, S_RUN,  ~m, 0));
        vecs.push_back(mk(0,0,0,1,8'h52, RX ? S_STOP : S_RUN, ~m, 0));

        foreach (vecs[i])
            cycle(vecs[i].rs, vecs[i].cl, vecs[i].md, vecs[i].rv, vecs[i].rd,
                  vecs[i].st, vecs[i].mode, vecs[i].drop, i + 1);

        // Run held for 10 cycles, then stopped.
        async_reset_check(100);
        cycle(1,0,0,0,8'h00, S_RUN, 0, 0, 101);
        for (int k = 0; k < 10; k++)
            cycle(0,0,0,0,8'h00, S_RUN, 0, 0, 102 + k);
        cycle(1,0,0,0,8'h00, S_STOP, 0, 0, 112);

        // Reset in the middle of CLEAR with mode set, then a fresh run command.
        cycle(0,0,1,0,8'h00, S_STOP, 1, 0, 120);
        cycle(1,0,0,0,8'h00, S_RUN,  1, 0, 121);
        cycle(0,1,0,0,8'h00, S_CLR,  1, 0, 122);
        async_reset_check(123);
        cycle(1,0,0,0,8'h00, S_RUN,  0, 0, 124);

        // Reset in the middle of RUN, then a full clear window from STOP.
        cycle(0,0,1,0,8'h00, S_RUN,  1, 0, 130);
        async_reset_check(131);
        cycle(0,1,0,0,8'h00, S_CLR,  0, 0, 132);
        cycle(0,0,0,0,8'h00, S_CLR,  0, 0, 133);
        cycle(0,0,0,0,8'h00, S_STOP, 0, 0, 134);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
